// File: rtl/rv32_pkg.sv
// Shared RV32I encodings used by the pipeline stages.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRWI = 3'b101;

  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [11:0]     TOHOST_ADDR_DFLT = 12'h51E;

  // Opcodes whose result is written back to the register file.
  function automatic logic is_wb_opcode(input logic [6:0] opc);
    return (opc == OPC_LUI)  || (opc == OPC_AUIPC) || (opc == OPC_OP) ||
           (opc == OPC_OP_IMM) || (opc == OPC_JAL) || (opc == OPC_JALR) ||
           (opc == OPC_LOAD);
  endfunction

endpackage

// File: rtl/mw_load_extract.sv
// Selects the addressed byte/half of a load word and sign- or zero-extends it.
module mw_load_extract
  import rv32_pkg::*;
(
  input  logic [31:0] dout,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel    = dout[8*off +: 8];
    half_sel    = off[1] ? dout[31:16] : dout[15:0];
    load_data_c = '0;
    case (funct3)
      F3_LB:   load_data_c = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  load_data_c = {24'b0, byte_sel};
      F3_LH:   load_data_c = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  load_data_c = {16'b0, half_sel};
      F3_LW:   load_data_c = dout;
      default: load_data_c = '0;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Stage 3 of the RV32I pipeline: data-cache request, X->MW register,
// writeback select and the tohost CSR.
module mem_wb_stage
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [11:0] TOHOST_ADDR = TOHOST_ADDR_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] pc_x,
  input  logic [31:0] inst_x,
  input  logic [31:0] alu_out_x,
  input  logic [31:0] rs2d_x,
  input  logic [31:0] csr_data_x,
  output logic [31:0] dcache_addr,
  output logic [31:0] dcache_din,
  output logic [3:0]  dcache_we,
  output logic        dcache_re,
  input  logic [31:0] dcache_dout,
  output logic [31:0] wb_data_mw,
  output logic        rwe_mw,
  output logic [4:0]  rd_mw,
  output logic [31:0] csr_tohost
);

  logic [6:0]  opc_x;
  logic [2:0]  f3_x;
  logic [1:0]  off_x;

  logic [31:0] inst_mw;
  logic [31:0] pc_mw;
  logic [31:0] alu_mw;
  logic [31:0] csr_data_mw;

  logic [6:0]  opc_mw;
  logic [2:0]  f3_mw;
  logic [11:0] csr_mw;
  logic [31:0] load_data;

  assign opc_x = inst_x[6:0];
  assign f3_x  = inst_x[14:12];
  assign off_x = alu_out_x[1:0];

  assign opc_mw = inst_mw[6:0];
  assign f3_mw  = inst_mw[14:12];
  assign csr_mw = inst_mw[31:20];
  assign rd_mw  = inst_mw[11:7];

  assign dcache_addr = {alu_out_x[31:2], 2'b00};
  assign dcache_re   = !reset && (opc_x == OPC_LOAD);

  // Store lane alignment; misaligned halves/words are dropped (no enables).
  always_comb begin
    dcache_we  = 4'b0000;
    dcache_din = rs2d_x;
    if (!reset && (opc_x == OPC_STORE)) begin
      case (f3_x)
        F3_SB: begin
          dcache_we  = 4'b0001 << off_x;
          dcache_din = rs2d_x << {off_x, 3'b000};
        end
        F3_SH: begin
          if (!off_x[0]) dcache_we = off_x[1] ? 4'b1100 : 4'b0011;
          dcache_din = off_x[1] ? {rs2d_x[15:0], 16'b0} : rs2d_x;
        end
        F3_SW: begin
          if (off_x == 2'b00) dcache_we = 4'b1111;
        end
        default: dcache_we = 4'b0000;
      endcase
    end
  end

  // X->MW pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_mw     <= INST_NOP;
      pc_mw       <= RESET_PC;
      alu_mw      <= '0;
      csr_data_mw <= '0;
    end else if (!stall) begin
      inst_mw     <= inst_x;
      pc_mw       <= pc_x;
      alu_mw      <= alu_out_x;
      csr_data_mw <= csr_data_x;
    end
  end

  mw_load_extract u_load_extract (
    .dout        (dcache_dout),
    .off         (alu_mw[1:0]),
    .funct3      (f3_mw),
    .load_data_c (load_data)
  );

  always_comb begin
    wb_data_mw = '0;
    case (opc_mw)
      OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM: wb_data_mw = alu_mw;
      OPC_JAL, OPC_JALR:                      wb_data_mw = pc_mw + 32'd4;
      OPC_LOAD:                               wb_data_mw = load_data;
      default:                                wb_data_mw = '0;
    endcase
  end

  assign rwe_mw = is_wb_opcode(opc_mw) && (rd_mw != 5'd0) && !stall && !reset;

  // tohost commits together with the instruction leaving MW.
  always_ff @(posedge clk) begin
    if (reset) begin
      csr_tohost <= '0;
    end else if (!stall && (opc_mw == OPC_SYSTEM) && (csr_mw == TOHOST_ADDR)) begin
      if (f3_mw == F3_CSRRW)       csr_tohost <= csr_data_mw;
      else if (f3_mw == F3_CSRRWI) csr_tohost <= {27'b0, inst_mw[19:15]};
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] pc_x, inst_x, alu_out_x, rs2d_x, csr_data_x;
  logic [31:0] dcache_addr, dcache_din, dcache_dout;
  logic [3:0]  dcache_we;
  logic        dcache_re;
  logic [31:0] wb_data_mw;
  logic        rwe_mw;
  logic [4:0]  rd_mw;
  logic [31:0] csr_tohost;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .pc_x        (pc_x),
    .inst_x      (inst_x),
    .alu_out_x   (alu_out_x),
    .rs2d_x      (rs2d_x),
    .csr_data_x  (csr_data_x),
    .dcache_addr (dcache_addr),
    .dcache_din  (dcache_din),
    .dcache_we   (dcache_we),
    .dcache_re   (dcache_re),
    .dcache_dout (dcache_dout),
    .wb_data_mw  (wb_data_mw),
    .rwe_mw      (rwe_mw),
    .rd_mw       (rd_mw),
    .csr_tohost  (csr_tohost)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_store(input logic [2:0] f3);
    return {7'b0, 5'd5, 5'd1, f3, 5'b0, 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_load(input logic [2:0] f3, input logic [4:0] rd);
    return {12'b0, 5'd1, f3, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [4:0] rd);
    return {20'b0, rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_csr(input logic [11:0] csr, input logic [4:0] rs1,
                                          input logic [2:0] f3);
    return {csr, rs1, f3, 5'd0, 7'b1110011};
  endfunction

  localparam logic [31:0] ADD_X7 = {7'b0, 5'd2, 5'd1, 3'b000, 5'd7, 7'b0110011};

  task automatic drive(input logic [31:0] inst, input logic [31:0] alu, input logic [31:0] pc);
    inst_x    = inst;
    alu_out_x = alu;
    pc_x      = pc;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    pc_x = '0; inst_x = NOP; alu_out_x = '0; rs2d_x = '0; csr_data_x = '0;
    dcache_dout = '0;

    // Store presented during reset must not issue.
    drive(enc_store(3'b010), 32'h1000, 32'h0);
    rs2d_x = 32'h1234_5678;
    #1;
    chk("reset_we", 32'(dcache_we), 32'h0);
    drive(enc_load(3'b010, 5'd6), 32'h1000, 32'h0);
    #1;
    chk("reset_re", 32'(dcache_re), 32'h0);
    step();
    step();
    chk("reset_rwe", 32'(rwe_mw), 32'h0);
    chk("reset_rd", 32'(rd_mw), 32'h0);
    chk("reset_tohost", csr_tohost, 32'h0);

    reset = 1'b0;
    drive(NOP, 32'h0, 32'h0);
    step();
    chk("idle_rwe", 32'(rwe_mw), 32'h0);
    chk("idle_wb", wb_data_mw, 32'h0);
    chk("idle_we", 32'(dcache_we), 32'h0);
    chk("idle_tohost", csr_tohost, 32'h0);

    // Store lane alignment.
    rs2d_x = 32'h0000_00AB;
    drive(enc_store(3'b000), 32'h1003, 32'h0); #1;
    chk("sb_addr", dcache_addr, 32'h1000);
    chk("sb_we", 32'(dcache_we), 32'h8);
    chk("sb_din", dcache_din, 32'hAB00_0000);
    chk("sb_re", 32'(dcache_re), 32'h0);
    drive(enc_store(3'b001), 32'h1001, 32'h0); #1;
    chk("sh_mis_we", 32'(dcache_we), 32'h0);
    rs2d_x = 32'h0000_BEEF;
    drive(enc_store(3'b001), 32'h1002, 32'h0); #1;
    chk("sh_hi_we", 32'(dcache_we), 32'hC);
    chk("sh_hi_din", dcache_din, 32'hBEEF_0000);
    rs2d_x = 32'hCAFE_F00D;
    drive(enc_store(3'b010), 32'h2000, 32'h0); #1;
    chk("sw_we", 32'(dcache_we), 32'hF);
    chk("sw_din", dcache_din, 32'hCAFE_F00D);
    drive(enc_store(3'b010), 32'h2002, 32'h0); #1;
    chk("sw_mis_we", 32'(dcache_we), 32'h0);

    // Loads: request in X, data returned while in MW.
    drive(enc_load(3'b000, 5'd6), 32'h1002, 32'h0); #1;
    chk("lb_re", 32'(dcache_re), 32'h1);
    chk("lb_we", 32'(dcache_we), 32'h0);
    step();
    dcache_dout = 32'h12F0_3456;
    drive(enc_load(3'b100, 5'd6), 32'h1002, 32'h0); #1;
    chk("lb_wb", wb_data_mw, 32'hFFFF_FFF0);
    chk("lb_rwe", 32'(rwe_mw), 32'h1);
    chk("lb_rd", 32'(rd_mw), 32'h6);
    step();
    drive(enc_load(3'b001, 5'd6), 32'h1002, 32'h0);
    chk("lbu_wb", wb_data_mw, 32'h0000_00F0);
    step();
    drive(enc_load(3'b010, 5'd9), 32'h1000, 32'h0);
    chk("lh_wb", wb_data_mw, 32'h0000_12F0);
    step();
    chk("lw_wb", wb_data_mw, 32'h12F0_3456);
    chk("lw_rd", 32'(rd_mw), 32'h9);

    // Jumps write pc+4.
    drive(enc_jal(5'd1), 32'h0, 32'h100);
    step();
    drive(enc_jal(5'd0), 32'h0, 32'h200);
    chk("jal_wb", wb_data_mw, 32'h104);
    chk("jal_rd", 32'(rd_mw), 32'h1);
    chk("jal_rwe", 32'(rwe_mw), 32'h1);
    step();
    chk("jal_x0_rwe", 32'(rwe_mw), 32'h0);
    chk("jal_x0_wb", wb_data_mw, 32'h204);

    // Stall holds MW and suppresses the write until released.
    drive(ADD_X7, 32'h55, 32'h300);
    step();
    drive(NOP, 32'h99, 32'h304);
    stall = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_rwe", 32'(rwe_mw), 32'h0);
      chk("stall_wb", wb_data_mw, 32'h55);
      chk("stall_rd", 32'(rd_mw), 32'h7);
      step();
    end
    stall = 1'b0; #1;
    chk("unstall_rwe", 32'(rwe_mw), 32'h1);
    chk("unstall_wb", wb_data_mw, 32'h55);
    step();
    chk("after_wb", wb_data_mw, 32'h99);
    chk("after_rwe", 32'(rwe_mw), 32'h0);

    // tohost CSR writes.
    drive(enc_csr(12'h51E, 5'd17, 3'b101), 32'h0, 32'h0);
    step();
    drive(NOP, 32'h0, 32'h0);
    chk("csrwi_pre", csr_tohost, 32'h0);
    chk("csrwi_rwe", 32'(rwe_mw), 32'h0);
    step();
    chk("csrwi_tohost", csr_tohost, 32'd17);
    drive(enc_csr(12'h51E, 5'd1, 3'b001), 32'h0, 32'h0);
    csr_data_x = 32'hDEAD_BEEF;
    step();
    drive(NOP, 32'h0, 32'h0);
    csr_data_x = 32'h0;
    step();
    chk("csrw_tohost", csr_tohost, 32'hDEAD_BEEF);
    drive(enc_csr(12'h51F, 5'd3, 3'b101), 32'h0, 32'h0);
    step();
    drive(NOP, 32'h0, 32'h0);
    step();
    chk("csr_other", csr_tohost, 32'hDEAD_BEEF);

    // tohost write held off by stall.
    drive(enc_csr(12'h51E, 5'd4, 3'b101), 32'h0, 32'h0);
    step();
    stall = 1'b1;
    step();
    chk("csr_stall", csr_tohost, 32'hDEAD_BEEF);
    stall = 1'b0;
    drive(NOP, 32'h0, 32'h0);
    step();
    chk("csr_unstall", csr_tohost, 32'd4);

    // Reset during stall loads the NOP.
    drive(ADD_X7, 32'h55, 32'h400);
    step();
    stall = 1'b1; reset = 1'b1; #1;
    chk("rst_stall_rwe", 32'(rwe_mw), 32'h0);
    step();
    chk("rst_stall_rd", 32'(rd_mw), 32'h0);
    chk("rst_stall_wb", wb_data_mw, 32'h0);
    chk("rst_stall_tohost", csr_tohost, 32'h0);
    reset = 1'b0; stall = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Stage 3 of the 3-stage RV32I pipeline. It sits directly downstream of the execute stage (Stage2).
- Consumes the execute-stage ALU result, forwarded rs2 data, pc and instruction. Issues the data-cache load/store request and holds the X→MW pipeline register.
- Produces the writeback triple (wb_data_mw, rwe_mw, rd_mw) that Stage2 forwards from and the regfile writes. Also owns the tohost CSR.

Parameters:
- RESET_PC, 32'h0000_0000, pc_mw value after reset.
- TOHOST_ADDR, 12'h51E, CSR address of tohost.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  memory-system stall; holds all MW state
- pc_x  in  32  execute-stage pc
- inst_x  in  32  execute-stage instruction
- alu_out_x  in  32  Stage2 alu_out (address or result)
- rs2d_x  in  32  Stage2 rs2d_clean (store data)
- csr_data_x  in  32  forwarded rs1 data for csrrw
- dcache_addr  out  32  word-aligned address {alu_out_x[31:2],2'b00}
- dcache_din  out  32  lane-shifted store data
- dcache_we  out  4  byte write enables
- dcache_re  out  1  load request
- dcache_dout  in  32  load data, valid the cycle after the request
- wb_data_mw  out  32  writeback data
- rwe_mw  out  1  register write enable
- rd_mw  out  5  destination register, inst_mw[11:7]
- csr_tohost  out  32  tohost CSR contents

Behaviour:
- Request path (combinational from X inputs):
  - dcache_re=1 iff inst_x opcode is LOAD.
  - For STORE, off = alu_out_x[1:0].
  - SB: we=4'b0001<<off; din=rs2d_x<<(8*off).
  - SH: off[0]=0 gives we=0011 or 1100 by off[1], din shifted 16*off[1]. off[0]=1 is misaligned: we=0.
  - SW: off=00 gives we=1111, din=rs2d_x. Otherwise misaligned: we=0.
  - Non-store instructions: we=0.
  - While reset=1: we=0 and re=0.
  - During stall the requests stay asserted unchanged; the cache tolerates repeated requests.
- MW register: inst_mw, pc_mw, alu_mw, csr_data_mw.
  - On reset: inst_mw=32'h0000_0013 (NOP), pc_mw=RESET_PC, alu_mw=0, csr_data_mw=0.
  - stall=1: hold all values.
  - Otherwise capture the X inputs every cycle. Latency X→MW is 1 cycle.
- Writeback select, from inst_mw opcode:
  - LUI/AUIPC/OP/OP-IMM: alu_mw.
  - JAL/JALR: pc_mw+4, mod 2^32.
  - LOAD: extract from dcache_dout by alu_mw[1:0] and funct3.
    - LB/LBU: byte off, sign- or zero-extended.
    - LH/LHU: half selected by off[1], extended.
    - LW: whole word.
  - Other opcodes: wb_data_mw=0.
- rwe_mw:
  - 1 iff the opcode is in the writeback list above, rd_mw≠0, stall=0 and reset=0.
  - CSR, BRANCH and STORE never write.
  - During stall rwe_mw=0. The held instruction writes on the first unstalled cycle.
- tohost:
  - Reset value 0.
  - On the rising edge with stall=0, if inst_mw is SYSTEM with funct3=001 and csr=TOHOST_ADDR: tohost←csr_data_mw.
  - With funct3=101 and the same CSR: tohost←{27'b0, inst_mw[19:15]}.
  - Other CSR addresses are ignored.
- Reset mid-stall: reset wins. The NOP is loaded and no write occurs that cycle.
- Simultaneous: a store in X and a load in MW are independent. The dcache returns data for the MW load while accepting the X store.

Decomposition:
- Shared package rv32_pkg:
  - opcode constants: LOAD, STORE, OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, SYSTEM
  - funct3 constants for loads, stores and CSR
  - NOP encoding
  - TOHOST_ADDR default
- Sub-module: mw_load_extract, a combinational byte/half select plus extend unit.
- Store alignment stays inline.

Test Plan:
- Reset then release, no stimulus → rwe_mw=0, csr_tohost=0, dcache_we=0, wb_data_mw=0 for NOP (rd=0).
- SB x5=0x000000AB to addr 0x1003 → dcache_addr=0x1000, we=4'b1000, din=0xAB000000. SH to 0x1001 → we=0.
- LB x6 at addr 0x1002, dcache_dout=0x12F0_3456 next cycle → wb_data_mw=0xFFFF_FFF0, rwe_mw=1, rd_mw=6. LBU same → 0x0000_00F0.
- JAL x1 at pc 0x100 → one cycle later wb_data_mw=0x104, rd_mw=1, rwe_mw=1. Same with rd=x0 → rwe_mw=0.
- ADD result 0x55 in MW, stall held 3 cycles → rwe_mw=0 and all MW outputs unchanged for 3 cycles. On the cycle stall drops: rwe_mw=1, wb_data_mw=0x55.
- csrwi tohost,17 → csr_tohost=17 one cycle after MW. csrw 0x51E with csr_data=0xDEAD_BEEF → 0xDEAD_BEEF. CSR 0x51F → unchanged.
